// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**N_IN vectors into a function-under-test, DWELL cycles each; done registers 2**N_IN*DWELL+1 cycles after start.
// No backpressure: start is taken only in IDLE and dropped otherwise. SWEEP_MISMATCH_EN adds the mismatch_cnt output.
module truth_table_sweeper #(
   parameter int                  N_IN     = 4,
   parameter int                  DWELL    = 2,
   parameter logic [2**N_IN-1:0]  EXPECTED = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                f_in,
   output logic [N_IN-1:0]     vec_out,
   output logic                busy,
   output logic                done,
   output logic [2**N_IN-1:0]  table_out,
   output logic                match
`ifdef SWEEP_MISMATCH_EN
   ,
   output logic [N_IN:0]       mismatch_cnt
`endif
);

   localparam int NV = 2**N_IN;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

   if (DWELL < 1) begin : g_bad_dwell
      $error("truth_table_sweeper: DWELL must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [NV-1:0]   table_q, table_d;
   logic            done_q, done_d;
   logic            match_q, match_d;

`ifdef SWEEP_MISMATCH_EN
   logic [N_IN:0]   mism_q, mism_d;
   logic [N_IN:0]   popcnt;
   logic [NV-1:0]   diff;

   always_comb begin
      diff   = table_q ^ EXPECTED;
      popcnt = '0;
      for (int i = 0; i < NV; i++) begin
         popcnt = popcnt + {{N_IN{1'b0}}, diff[i]};
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      table_d = table_q;
      done_d  = 1'b0;
      match_d = match_q;
`ifdef SWEEP_MISMATCH_EN
      mism_d  = mism_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               dwell_d = DW'(DWELL - 1);
               table_d = '0;
               match_d = 1'b0;
`ifdef SWEEP_MISMATCH_EN
               mism_d  = '0;
`endif
            end
         end
         S_SETTLE: begin
            if (dwell_q != '0) begin
               dwell_d = dwell_q - 1'b1;
            end else begin
               // Last cycle of the dwell window: the FUT output has had DWELL cycles to settle.
               table_d[idx_q] = f_in;
               if (idx_q == {N_IN{1'b1}}) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  dwell_d = DW'(DWELL - 1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            match_d = (table_q == EXPECTED);
`ifdef SWEEP_MISMATCH_EN
            mism_d  = popcnt;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         dwell_q <= '0;
         table_q <= '0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
`ifdef SWEEP_MISMATCH_EN
         mism_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         table_q <= table_d;
         done_q  <= done_d;
         match_q <= match_d;
`ifdef SWEEP_MISMATCH_EN
         mism_q  <= mism_d;
`endif
      end
   end

   // Vector drive is decoded from state so an async reset clears it in the same cycle.
   assign vec_out   = (state_q == S_SETTLE) ? idx_q : '0;
   assign busy      = (state_q == S_SETTLE);
   assign done      = done_q;
   assign table_out = table_q;
   assign match     = match_q;
`ifdef SWEEP_MISMATCH_EN
   assign mismatch_cnt = mism_q;
`endif

endmodule
